// File: rtl/cmprs_pkg.sv
// Shared definitions for the carry-save compressor datapath.
// Row-count helpers size the reduction tree at elaboration time.
package cmprs_pkg;

    localparam int MAX_OPS = 8;

    typedef enum logic {
        ACC_IDLE = 1'b0,
        ACC_RUN  = 1'b1
    } acc_state_e;

    // Rows left after lvl levels: each group of three becomes two.
    function automatic int rows_after(int rows, int lvl);
        int r;
        r = rows;
        for (int i = 0; i < lvl; i++) begin
            r = 2 * (r / 3) + r % 3;
        end
        return r;
    endfunction

    function automatic int tree_depth(int rows);
        int r;
        int d;
        r = rows;
        d = 0;
        for (int i = 0; i < 32; i++) begin
            if (r > 2) begin
                r = 2 * (r / 3) + r % 3;
                d++;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/cmprs_2to1.sv
// 2:1 compressor cell (half adder).
// Used where a column holds only two bits.
module cmprs_2to1 (
    input  logic [1:0] data,
    output logic       sum,
    output logic       cout
);

    assign sum  = data[0] ^ data[1];
    assign cout = data[0] & data[1];

endmodule

// File: rtl/cmprs_3to2.sv
// 3:2 compressor cell (full adder).
// Basic building block of the carry-save tree.
module cmprs_3to2 (
    input  logic [2:0] data,
    output logic       sum,
    output logic       cout
);

    assign sum  = ^data;
    assign cout = (data[0] & data[1])
                | (data[0] & data[2])
                | (data[1] & data[2]);

endmodule

// File: rtl/cmprs_acc_pipe.sv
// Multi-operand carry-save compressor with redundant accumulator.
// Tree feeds a stage-1 row register, then a carry-propagate stage.
module cmprs_acc_pipe
    import cmprs_pkg::*;
#(
    parameter int NUM_OPS   = 4,
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = WIDTH + 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_OPS*WIDTH-1:0] in_data,
    input  logic                     in_signed,
    input  logic                     in_acc,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_WIDTH-1:0]     out_sum,
    output logic                     out_last
);

    localparam int NR    = NUM_OPS + 2;
    localparam int DEPTH = tree_depth(NR);
    localparam int AW    = ACC_WIDTH;

    acc_state_e state_q;
    acc_state_e state_d;

    logic [AW-1:0] acc_s;
    logic [AW-1:0] acc_c;
    logic          use_acc;
    logic          accept;
    logic          s2_ready;

    logic          s1_valid;
    logic [AW-1:0] s1_s;
    logic [AW-1:0] s1_c;
    logic          s1_last;

    logic [AW-1:0] fin_s;
    logic [AW-1:0] fin_c;

    assign s2_ready = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_ready;
    assign accept   = in_valid && in_ready;
    // Rows are zero while idle, so gating on state is free.
    assign use_acc  = in_acc && (state_q == ACC_RUN);

    for (genvar l = 0; l <= DEPTH; l++) begin : lv
        localparam int N = rows_after(NR, l);
        logic [AW-1:0] r [N];

        if (l == 0) begin : g_in
            for (genvar k = 0; k < NUM_OPS; k++) begin : g_op
                logic [WIDTH-1:0] op;
                logic             ext;
                assign op   = in_data[k*WIDTH +: WIDTH];
                assign ext  = in_signed & op[WIDTH-1];
                assign r[k] = {{(AW-WIDTH){ext}}, op};
            end
            assign r[NUM_OPS]   = acc_s & {AW{use_acc}};
            assign r[NUM_OPS+1] = acc_c & {AW{use_acc}};
        end else begin : g_red
            localparam int NP  = rows_after(NR, l - 1);
            localparam int G   = NP / 3;
            localparam int REM = NP % 3;

            for (genvar g = 0; g < G; g++) begin : g_fa
                logic [AW-1:0] a;
                logic [AW-1:0] b;
                logic [AW-1:0] c;
                logic [AW-1:0] s;
                logic [AW-2:0] co;
                assign a = lv[l-1].r[3*g];
                assign b = lv[l-1].r[3*g+1];
                assign c = lv[l-1].r[3*g+2];
                for (genvar k = 0; k < AW - 1; k++) begin : g_col
                    cmprs_3to2 u_fa (
                        .data ({a[k], b[k], c[k]}),
                        .sum  (s[k]),
                        .cout (co[k])
                    );
                end
                // Top column carry falls off the result width.
                assign s[AW-1]   = a[AW-1] ^ b[AW-1] ^ c[AW-1];
                assign r[2*g]    = s;
                assign r[2*g+1]  = {co, 1'b0};
            end

            if (REM == 2) begin : g_ha
                logic [AW-1:0] a;
                logic [AW-1:0] b;
                logic [AW-1:0] s;
                logic [AW-2:0] co;
                assign a = lv[l-1].r[3*G];
                assign b = lv[l-1].r[3*G+1];
                for (genvar k = 0; k < AW - 1; k++) begin : g_col
                    cmprs_2to1 u_ha (
                        .data ({a[k], b[k]}),
                        .sum  (s[k]),
                        .cout (co[k])
                    );
                end
                assign s[AW-1]    = a[AW-1] ^ b[AW-1];
                assign r[2*G]     = s;
                assign r[2*G+1]   = {co, 1'b0};
            end else if (REM == 1) begin : g_pass
                assign r[2*G] = lv[l-1].r[3*G];
            end
        end
    end

    assign fin_s = lv[DEPTH].r[0];
    assign fin_c = lv[DEPTH].r[1];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACC_IDLE: if (accept && !in_last) state_d = ACC_RUN;
            ACC_RUN:  if (accept && in_last)  state_d = ACC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACC_IDLE;
            acc_s   <= '0;
            acc_c   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                acc_s <= in_last ? '0 : fin_s;
                acc_c <= in_last ? '0 : fin_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_s     <= '0;
            s1_c     <= '0;
            s1_last  <= 1'b0;
        end else begin
            if (in_ready) s1_valid <= in_valid;
            if (accept) begin
                s1_s    <= fin_s;
                s1_c    <= fin_c;
                s1_last <= in_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_last  <= 1'b0;
        end else begin
            if (s2_ready) out_valid <= s1_valid;
            if (s1_valid && s2_ready) begin
                out_sum  <= s1_s + s1_c;
                out_last <= s1_last;
            end
        end
    end

endmodule
